// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA read channel.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_HOLD
  } dma_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int unsigned BOUNDARY_4K = 4096;

endpackage

// File: rtl/dma_sync_fifo.sv
// Synchronous FIFO with a registered-array output: an entry pushed on one edge
// is presented on pop_data (with empty low) from the following cycle.
module dma_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Occupancy flags; a push into a full FIFO is accepted when a pop frees the slot.
  always_comb begin
    count    = wr_ptr - rd_ptr;
    full     = (count == (AW+1)'(DEPTH));
    empty    = (count == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    pop_data = mem[rd_ptr[AW-1:0]];
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Read/write pointers with wrap bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/dma_read_channel.sv
// AXI4 read DMA channel: fetches a byte region in 4KB-safe INCR bursts,
// buffers beats in a FIFO and drains them onto an AXI-Stream master.
// Optional feature macro: DMA_RD_PERF_CNT_EN (busy/stall performance counters).
module dma_read_channel
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]           size,
  output logic                  done,
  output logic                  error,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
`ifdef DMA_RD_PERF_CNT_EN
  ,
  output logic [31:0]           perf_busy_cycles,
  output logic [31:0]           perf_stall_cycles
`endif
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int BSHIFT = $clog2(BYTES);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  dma_state_e            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           remaining;
  logic [8:0]            len;
  logic [8:0]            beat_cnt;
  logic                  err;

  logic [31:0]           to_4k;
  logic [31:0]           calc_len;
  logic [31:0]           free_slots;
  logic                  r_hs;
  logic                  last_exp;
  logic                  burst_end;
  logic                  beat_err;
  logic                  push_last;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH:0]   fifo_out;

  // Burst sizing and per-beat classification of the R channel.
  always_comb begin
    to_4k      = (BOUNDARY_4K - 32'(addr[11:0])) >> BSHIFT;
    calc_len   = 32'(MAX_BURST);
    if (remaining < calc_len) calc_len = remaining;
    if (to_4k < calc_len)     calc_len = to_4k;
    free_slots = 32'(FIFO_DEPTH) - 32'(fifo_count);
    r_hs       = m_axi_rvalid && m_axi_rready;
    last_exp   = (beat_cnt == len - 9'd1);
    // An early rlast also closes the burst; a missing rlast is overridden by the beat count.
    burst_end  = m_axi_rlast || last_exp;
    beat_err   = (m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != last_exp);
    // After any error the closing beat of the burst becomes the frame end.
    push_last  = (remaining == 32'd1) || ((err || beat_err) && burst_end);
  end

  dma_sync_fifo #(
    .WIDTH(DATA_WIDTH + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (r_hs),
    .push_data({m_axi_rdata, push_last}),
    .pop      (m_axis_tvalid && m_axis_tready),
    .pop_data (fifo_out),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Stream side is driven straight from the FIFO head.
  always_comb begin
    m_axis_tvalid = !fifo_empty;
    m_axis_tdata  = fifo_out[DATA_WIDTH:1];
    m_axis_tlast  = fifo_out[0];
  end

  // Transfer control FSM with registered AXI and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      addr          <= '0;
      remaining     <= '0;
      len           <= '0;
      beat_cnt      <= '0;
      err           <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      busy          <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            addr      <= base_addr & ~ADDR_WIDTH'(BYTES - 1);
            remaining <= (size >> BSHIFT) + 32'(|size[BSHIFT-1:0]);
            busy      <= 1'b1;
            state     <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (remaining == '0) begin
            state <= ST_DONE;
          end else if (!fifo_full && free_slots >= calc_len) begin
            len           <= calc_len[8:0];
            m_axi_araddr  <= addr;
            m_axi_arlen   <= 8'(calc_len - 32'd1);
            m_axi_arvalid <= 1'b1;
            state         <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            beat_cnt      <= '0;
            state         <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (r_hs) begin
            remaining <= remaining - 32'd1;
            beat_cnt  <= beat_cnt + 9'd1;
            if (beat_err) err <= 1'b1;
            if (burst_end) begin
              m_axi_rready <= 1'b0;
              addr         <= addr + (ADDR_WIDTH'(len) << BSHIFT);
              state        <= (remaining == 32'd1 || err || beat_err) ? ST_DONE : ST_CALC;
            end
          end
        end
        ST_DONE: begin
          if (fifo_empty) begin
            done  <= 1'b1;
            error <= err;
            busy  <= 1'b0;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!req) begin
            err   <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DMA_RD_PERF_CNT_EN
  // Saturating busy and stream-stall cycle counters, cleared at launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else if (state == ST_IDLE && req) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (busy && perf_busy_cycles != '1)
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (m_axis_tvalid && !m_axis_tready && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_dma_read_channel.sv
// Scoreboard bench for dma_read_channel: a transfer-level model queues the
// expected AR bursts and stream beats; a negedge monitor pops and compares.
module tb_dma_read_channel;
  import dma_pkg::*;

  localparam int DW = 128;
  localparam int AW = 32;
  localparam int MB = 16;
  localparam int FD = 32;

  logic          clk;
  logic          rst_n;
  logic          req;
  logic [AW-1:0] base_addr;
  logic [31:0]   size_i;
  logic          done;
  logic          error;
  logic          busy;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;

  dma_read_channel #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MAX_BURST (MB),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .base_addr    (base_addr),
    .size         (size_i),
    .done         (done),
    .error        (error),
    .busy         (busy),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arlen  (m_axi_arlen),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rlast  (m_axi_rlast),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] a; logic [7:0] l; } ar_t;
  typedef struct packed { logic [127:0] d; logic l; } st_t;

  ar_t exp_ar[$];
  st_t exp_st[$];
  logic exp_err;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int done_cnt = 0;
  int r_cnt = 0;
  int t_cnt = 0;
  int occ = 0;
  int max_occ = 0;
  int d0_g = 0;
  int tmode = 1;   // 0 random tready, 1 always ready, 2 stalled
  int inj = 0;     // 0 none, 1 SLVERR beat 2, 2 missing rlast, 3 early rlast (first burst)

  function automatic void chk(string name, logic [127:0] act, logic [127:0] req_v);
    n_total++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req_v);
  endfunction

  function automatic logic [127:0] beat_data(logic [31:0] a);
    return {a, ~a, a ^ 32'hA5A5_5A5A, a + 32'h1357_9BDF};
  endfunction

  // Transfer-level reference: split the aligned region into 4KB-safe bursts.
  task automatic expect_xfer(input logic [31:0] base, input logic [31:0] sz, input int mode);
    logic [31:0] a;
    int unsigned rem, n, room, keep;
    st_t st;
    a = base & 32'hFFFF_FFF0;
    rem = (sz >> 4) + ((sz[3:0] != 4'd0) ? 32'd1 : 32'd0);
    exp_err = (mode != 0);
    while (rem > 0) begin
      room = (4096 - (a % 4096)) / 16;
      n = (rem < MB) ? rem : MB;
      if (room < n) n = room;
      exp_ar.push_back('{a: a, l: 8'(n - 1)});
      keep = (mode == 3) ? 3 : n;
      for (int unsigned i = 0; i < keep; i++) begin
        st.d = beat_data(a + 16 * i);
        st.l = (rem == i + 1) || (mode != 0 && i == keep - 1);
        exp_st.push_back(st);
      end
      if (mode != 0) break;
      a = a + 16 * n;
      rem = rem - n;
    end
  endtask

  // Stream ready driver.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (tmode)
        0: m_axis_tready = ($urandom_range(0, 1) == 1);
        1: m_axis_tready = 1'b1;
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // AXI read slave: random AR/R latency, data derived from the beat address.
  logic [31:0] s_addr;
  int s_len, s_beat, s_burst_idx;
  bit s_active, s_rr, s_end;
  initial begin
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    m_axi_rdata = '0; m_axi_rresp = AXI_RESP_OKAY;
    s_active = 0; s_rr = 0; s_end = 0; s_beat = 0; s_len = 0; s_burst_idx = 0; s_addr = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        s_active = 0; s_rr = 0;
        continue;
      end
      if (!busy) s_burst_idx = 0;
      if (m_axi_arready) begin
        m_axi_arready = 1'b0; s_active = 1; s_beat = 0;
      end else if (!s_active && m_axi_arvalid && $urandom_range(0, 2) == 0) begin
        m_axi_arready = 1'b1; s_addr = m_axi_araddr; s_len = int'(m_axi_arlen) + 1;
      end
      if (m_axi_rvalid && s_rr) begin
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        if (s_end) begin s_active = 0; s_burst_idx++; end
        else s_beat++;
      end
      if (s_active && !m_axi_rvalid && $urandom_range(0, 3) != 0) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata = beat_data(s_addr + 32'(16 * s_beat));
        m_axi_rresp = AXI_RESP_OKAY;
        s_end = (s_beat == s_len - 1);
        m_axi_rlast = s_end;
        if (inj == 1 && s_burst_idx == 0 && s_beat == 1) m_axi_rresp = AXI_RESP_SLVERR;
        if (inj == 2 && s_burst_idx == 0 && s_end) m_axi_rlast = 1'b0;
        if (inj == 3 && s_burst_idx == 0 && s_beat == 2) begin m_axi_rlast = 1'b1; s_end = 1; end
      end
      s_rr = m_axi_rready;
    end
  end

  // Monitor: handshakes are sampled mid-cycle, ahead of the edge that completes them.
  ar_t ar_e;
  st_t st_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      r_cnt = 0; t_cnt = 0;
    end else begin
      occ = r_cnt - t_cnt;
      if (occ > max_occ) max_occ = occ;
      if (m_axi_arvalid && m_axi_arready) begin
        chk("ar_expected", exp_ar.size() != 0, 1);
        if (exp_ar.size() != 0) begin
          ar_e = exp_ar.pop_front();
          chk("ar_addr", m_axi_araddr, ar_e.a);
          chk("ar_len", m_axi_arlen, ar_e.l);
        end
        chk("ar_space", (occ + int'(m_axi_arlen) + 1) <= FD, 1);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        chk("st_expected", exp_st.size() != 0, 1);
        if (exp_st.size() != 0) begin
          st_e = exp_st.pop_front();
          chk("st_data", m_axis_tdata, st_e.d);
          chk("st_last", m_axis_tlast, st_e.l);
        end
        t_cnt++;
      end
      if (m_axi_rvalid && m_axi_rready) r_cnt++;
      if (done) begin
        chk("done_error", error, exp_err);
        chk("done_busy", busy, 0);
        done_cnt++;
      end
      if (error) chk("error_with_done", done, 1);
    end
  end

  task automatic start_xfer(input logic [31:0] base, input logic [31:0] sz, input int mode, input bit hold);
    int c;
    c = 0;
    while (busy && c < 4000) begin @(posedge clk); #1; c++; end
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    inj = mode;
    expect_xfer(base, sz, mode);
    base_addr = base; size_i = sz; req = 1'b1;
    d0_g = done_cnt;
    @(posedge clk); #1;
    chk("busy_after_launch", busy, 1);
    if (!hold) req = 1'b0;
  endtask

  task automatic finish_xfer();
    int c;
    c = 0;
    while (done_cnt == d0_g && c < 4000) begin @(posedge clk); #1; c++; end
    chk("done_seen", done_cnt != d0_g, 1);
    chk("ar_drained", exp_ar.size(), 0);
    chk("st_drained", exp_st.size(), 0);
  endtask

  task automatic run_xfer(input logic [31:0] base, input logic [31:0] sz, input int mode);
    start_xfer(base, sz, mode, 1'b0);
    finish_xfer();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int d_hold;
    rst_n = 1'b0; req = 1'b0; base_addr = '0; size_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {m_axi_arvalid, m_axi_rready, m_axis_tvalid, done, error, busy,
                          m_axi_araddr, m_axi_arlen}, 0);
    @(negedge clk) rst_n = 1'b1;

    // Directed cases
    tmode = 1;
    run_xfer(32'h0000_1000, 64, 0);
    run_xfer(32'h0000_0FC0, 512, 0);
    run_xfer(32'h0000_0100, 20, 0);

    // size=0: no AR, done two cycles after launch
    start_xfer(32'h0000_0040, 0, 0, 1'b1);
    c = 1;
    while (!done && c < 20) begin @(posedge clk); #1; c++; end
    chk("size0_done_latency", c, 3);
    req = 1'b0;
    finish_xfer();

    // Stream backpressure: FIFO fills to depth and AR issue stops
    tmode = 2;
    max_occ = 0;
    start_xfer(32'h0000_4000, 1024, 0, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    chk("bp_max_occupancy", max_occ, FD);
    chk("bp_ar_pending", exp_ar.size(), 2);
    tmode = 1;
    finish_xfer();

    // Error cases
    run_xfer(32'h0000_2000, 1024, 1);
    run_xfer(32'h0000_3000, 300, 2);
    run_xfer(32'h0000_5000, 512, 3);

    // Randomized transfers with random stream readiness
    tmode = 0;
    for (int k = 0; k < 10; k++)
      run_xfer($urandom() & 32'h0003_FFFF, $urandom_range(0, 700), 0);
    tmode = 1;

    // Asynchronous reset in the middle of a data phase
    start_xfer(32'h0000_8000, 1024, 0, 1'b0);
    c = 0;
    while (!m_axi_rready && c < 200) begin @(posedge clk); #1; c++; end
    chk("reset_reached_data", m_axi_rready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async_outputs", {m_axi_arvalid, m_axi_rready, m_axis_tvalid, done, error, busy,
                                m_axi_araddr, m_axi_arlen}, 0);
    exp_ar.delete();
    exp_st.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_xfer(32'h0000_8000, 200, 0);

    // Holding req after done must not relaunch
    start_xfer(32'h0000_9000, 100, 0, 1'b1);
    finish_xfer();
    d_hold = done_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("hold_no_relaunch_busy", busy, 0);
    chk("hold_no_extra_done", done_cnt, d_hold);
    req = 1'b0;
    run_xfer(32'h0000_9100, 48, 0);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
